btn_conditioner: RTL

- Input-side conditioner for the Nexys-4 game board: takes raw, bouncing push-buttons (L, R, U, D, C) and produces clean one-shot and auto-repeat pulses for the game core.
- Sits between the board button pins and the game FSM; it is the input counterpart of the SSD output path.
- Each button has its own synchronizer, debounce counter and single/multi-pulse state machine.

---
 rtl/btn_conditioner.sv | 116 +++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-button synchronizer, debouncer and single/auto-repeat pulse FSM
// Optional auto-repeat (MCEN_ST/CCR states) is built only when BTN_AUTOREPEAT_EN is defined;
// without it mcen mirrors scen and HOLD_CYCLES/REP_CYCLES have no effect.
module btn_conditioner #(
   parameter int N_BTN       = 5,
   parameter int CNT_W       = 27,
   parameter int DB_CYCLES   = 1_000_000,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int REP_CYCLES  = 25_000_000
) (
   input  logic             board_clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] dpb,
   output logic [N_BTN-1:0] scen,
   output logic [N_BTN-1:0] mcen,
   output logic             any_scen
);

`ifdef BTN_AUTOREPEAT_EN
   typedef enum logic [2:0] {INI, WQ, SCEN_ST, WH, WFCR, MCEN_ST, CCR} state_t;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);
`else
   typedef enum logic [2:0] {INI, WQ, SCEN_ST, WH, WFCR} state_t;
`endif

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic [1:0]       r_sync;
      logic             w_btn_s;
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic             w_dpb;
      logic             w_scen;
      logic             w_mcen;

      assign w_btn_s = r_sync[1];

      // Two-flop synchronizer: the raw pin is asynchronous to board_clk
      always_ff @(posedge board_clk or posedge reset) begin
         if (reset) r_sync <= 2'b00;
         else       r_sync <= {r_sync[0], btn_raw[i]};
      end

      // State register; the counter restarts on every state change so each state times itself
      always_ff @(posedge board_clk or posedge reset) begin
         if (reset) begin
            r_state <= INI;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else                        r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      // Next-state logic and Moore output decode
      always_comb begin
         w_state_nxt = r_state;
         w_dpb       = 1'b0;
         w_scen      = 1'b0;
         w_mcen      = 1'b0;
         case (r_state)
            INI: begin
               if (w_btn_s) w_state_nxt = WQ;
            end
            WQ: begin
               if (!w_btn_s)               w_state_nxt = INI;
               else if (r_cnt == DB_LAST)  w_state_nxt = SCEN_ST;
            end
            SCEN_ST: begin
               w_dpb       = 1'b1;
               w_scen      = 1'b1;
               w_mcen      = 1'b1;
               w_state_nxt = WH;
            end
            WH: begin
               w_dpb = 1'b1;
               if (!w_btn_s) w_state_nxt = WFCR;
`ifdef BTN_AUTOREPEAT_EN
               else if (r_cnt == HOLD_LAST) w_state_nxt = MCEN_ST;
`endif
            end
            WFCR: begin
               w_dpb = 1'b1;
               // A bounce back to high returns to WH without a fresh scen
               if (w_btn_s)                w_state_nxt = WH;
               else if (r_cnt == DB_LAST)  w_state_nxt = INI;
            end
`ifdef BTN_AUTOREPEAT_EN
            MCEN_ST: begin
               w_dpb       = 1'b1;
               w_mcen      = 1'b1;
               w_state_nxt = CCR;
            end
            CCR: begin
               w_dpb = 1'b1;
               if (!w_btn_s)               w_state_nxt = WFCR;
               else if (r_cnt == REP_LAST) w_state_nxt = MCEN_ST;
            end
`endif
            default: w_state_nxt = INI;
         endcase
      end

      assign dpb[i]  = w_dpb;
      assign scen[i] = w_scen;
      assign mcen[i] = w_mcen;
   end

   assign any_scen = |scen;

endmodule
